// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (request-to-send, odd parity, ACK check).
// Optional build macro PS2_TX_RETRY_EN enables automatic retries after NACK/timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RETRY_LIMIT    = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;

  localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRY_LIMIT);

`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_DATA,
    S_ACK,
    S_DONE,
    S_FAIL
  } state_t;

  state_t state, state_n;

  logic [2:0]    clk_s;
  logic [1:0]    dat_s;
  logic          clk_sync, dat_sync, fall;

  logic [7:0]    data_q, data_n;
  logic          par_q, par_n;
  logic [IW-1:0] inh_q, inh_n;
  logic [WW-1:0] wd_q, wd_n;
  logic [3:0]    k_q, k_n;
  logic          drv_q, drv_n;
  logic [RW-1:0] retry_q, retry_n;

  logic clk_oe_q, clk_oe_n;
  logic dat_oe_q, dat_oe_n;
  logic ready_q, ready_n;
  logic done_q, done_n;
  logic err_q, err_n;
  logic wd_expired;

  // Pins idle high, so the synchronisers reset high to avoid a false edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_s <= 3'b111;
      dat_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[1:0], ps2_clk_in};
      dat_s <= {dat_s[0], ps2_dat_in};
    end
  end

  assign clk_sync   = clk_s[1];
  assign dat_sync   = dat_s[1];
  assign fall       = clk_s[2] & ~clk_s[1];
  assign wd_expired = ~fall & (wd_q == WD_LAST);

  always_comb begin
    state_n = state;
    data_n  = data_q;
    par_n   = par_q;
    inh_n   = inh_q;
    wd_n    = wd_q;
    k_n     = k_q;
    drv_n   = drv_q;
    retry_n = retry_q;

    if (state == S_RTS || state == S_DATA || state == S_ACK) begin
      wd_n = fall ? '0 : wd_q + 1'b1;
    end

    unique case (state)
      S_IDLE: begin
        if (tx_valid) begin
          data_n  = tx_data;
          par_n   = ~^tx_data;
          retry_n = '0;
          inh_n   = '0;
          state_n = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          state_n = S_RTS;
          k_n     = '0;
          wd_n    = '0;
          drv_n   = 1'b1;
        end else begin
          inh_n = inh_q + 1'b1;
        end
      end
      S_RTS, S_DATA: begin
        if (fall) begin
          k_n     = k_q + 4'd1;
          state_n = S_DATA;
          unique case (1'b1)
            (k_q < 4'd8):  drv_n = ~data_q[k_q[2:0]];
            (k_q == 4'd8): drv_n = ~par_q;
            (k_q == 4'd9): drv_n = 1'b0;
            default: begin
              drv_n   = 1'b0;
              state_n = dat_sync ? S_FAIL : S_ACK;
            end
          endcase
        end else if (wd_expired) begin
          state_n = S_FAIL;
        end
      end
      S_ACK: begin
        if (clk_sync && dat_sync) begin
          state_n = S_DONE;
        end else if (wd_expired) begin
          state_n = S_FAIL;
        end
      end
      S_DONE: state_n = S_IDLE;
      S_FAIL: begin
        if (RETRY_EN && retry_q < RETRY_MAX) begin
          retry_n = retry_q + 1'b1;
          inh_n   = '0;
          state_n = S_INHIBIT;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are registered from the next state so the pins never glitch.
    clk_oe_n = (state_n == S_INHIBIT);
    dat_oe_n = ((state_n == S_INHIBIT) && (inh_n == INH_LAST))
             | (((state_n == S_RTS) || (state_n == S_DATA)) && drv_n);
    ready_n  = (state_n == S_IDLE);
    done_n   = (state_n == S_DONE);
    err_n    = (state_n == S_FAIL)
             && !(RETRY_EN && retry_n < RETRY_MAX);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      inh_q    <= '0;
      wd_q     <= '0;
      k_q      <= '0;
      drv_q    <= 1'b0;
      retry_q  <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      data_q   <= data_n;
      par_q    <= par_n;
      inh_q    <= inh_n;
      wd_q     <= wd_n;
      k_q      <= k_n;
      drv_q    <= drv_n;
      retry_q  <= retry_n;
      clk_oe_q <= clk_oe_n;
      dat_oe_q <= dat_oe_n;
      ready_q  <= ready_n;
      done_q   <= done_n;
      err_q    <= err_n;
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_ready   = ready_q;
  assign tx_busy    = ~ready_q;
  assign tx_done    = done_q;
  assign tx_error   = err_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Complements the existing PS/2 receive path (PS2_Interface), which only listens to the keyboard.
- Sends one command byte to the keyboard using the host request-to-send protocol, e.g. 0xED set-LEDs or 0xF4 enable-scanning.
- Drives the shared open-drain ps2_clock/ps2_data pins through active-low-drive enables. At the top level these enables gate tristate buffers alongside PS2_Interface.

Parameters:
- INHIBIT_CYCLES, 6000, clock cycles ps2_clock is held low before request-to-send (120 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000, max cycles allowed between device clock falling edges, or after the last edge, before aborting (20 ms).
- RETRY_LIMIT, 2, automatic retries after NACK/timeout; used only with PS2_TX_RETRY_EN.

Ports:
- clock  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous active-low reset
- tx_data  in  8  command byte
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  high when idle and able to accept a byte
- ps2_clk_in  in  1  raw ps2_clock pin value
- ps2_dat_in  in  1  raw ps2_data pin value
- ps2_clk_oe  out  1  1 = drive ps2_clock low, 0 = release
- ps2_dat_oe  out  1  1 = drive ps2_data low, 0 = release
- tx_busy  out  1  high from accept until done/error
- tx_done  out  1  one-cycle pulse: byte sent and ACKed
- tx_error  out  1  one-cycle pulse: NACK or timeout

Behaviour:
- Interface decision: one clock (clock); reset is asynchronous and active-low (resetn).
- Reset values: state IDLE; all oe outputs 0; tx_ready=1; tx_busy=0; tx_done=0; tx_error=0; edge counter 0.
- Reset asserted mid-frame releases both lines immediately (asynchronous).
- Input synchronisation: ps2_clk_in and ps2_dat_in each pass through a 2-flop synchroniser.
- Falling edge: a third registered copy of the synchronised clock equals 1 while the synchronised value equals 0.
- Accept: tx_valid && tx_ready in IDLE latches tx_data and computes parity = ~^tx_data (odd parity). tx_valid is ignored at all other times.
- IDLE -> INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles.
- INHIBIT -> RTS: dat_oe=1 (start bit 0), then clk_oe=0 the cycle after. Edge counter k=0; watchdog cleared.
- RTS/DATA, on each device falling edge k++:
  - k=1..8: dat_oe = ~data[k-1] (LSB first).
  - k=9: dat_oe = ~parity.
  - k=10: dat_oe=0 (stop bit 1).
  - k=11: sample synchronised data; 0 -> ACK state, 1 -> FAIL.
- ACK: wait until synchronised clock and data are both 1, then DONE.
- DONE: one-cycle tx_done pulse, then IDLE (tx_ready=1 the following cycle).
- FAIL: both oe=0; one-cycle tx_error pulse; then IDLE.
- Watchdog: counter cleared on every falling edge and on entry to RTS. If it reaches TIMEOUT_CYCLES in RTS, DATA, or ACK -> FAIL.
- tx_ready = (state==IDLE). tx_busy = ~tx_ready.
- The receive path ignores frames while tx_busy is high; the top level gates this.
- Counter widths are sized by $clog2 of the respective parameter. No wrap is possible because the watchdog saturates into FAIL.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined: FAIL returns to INHIBIT with the same latched byte, up to RETRY_LIMIT times. tx_error pulses only when retries are exhausted. The retry count resets on accept.
- Undefined: FAIL goes directly to the tx_error pulse and IDLE; RETRY_LIMIT is unused.

Test Plan:
- Send 0xED, device model ACKs -> clk_oe high exactly 6000 cycles. Data bits sampled at device rising edges are 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1. One tx_done pulse; tx_error stays 0.
- Send 0xF4 -> bits 0,0,1,0,1,1,1,1, parity 0; tx_done pulses once; tx_ready returns 1 the cycle after.
- Device releases data high at the 11th falling edge (NACK) -> tx_error pulse, no tx_done, both oe=0. With PS2_TX_RETRY_EN, 3 full INHIBIT attempts occur before tx_error.
- Device never clocks after RTS -> tx_error exactly TIMEOUT_CYCLES after entering RTS, with ps2_dat_oe released.
- tx_valid pulsed with 0x55 during the 0xED transfer -> ignored; only 0xED bits appear on the bus.
- resetn driven low at falling edge 5 -> ps2_clk_oe=ps2_dat_oe=0 with no clock edge required. tx_ready=1 after release; a new 0xF4 send completes normally.
